// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// State and operation encodings plus the default wait-state count.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ISSUE,
        DONE
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

    localparam int WAIT_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates one read and one write requester onto a single-port SRAM.
// Adds a fixed number of wait states before each SRAM strobe.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              RamRead,
    input  logic [31:0]       RamReadAddress,
    input  logic              RamWrite,
    input  logic [31:0]       RamWriteAddress,
    input  logic [31:0]       RamWriteData,
    output logic              DoneReadingData,
    output logic              DoneWritingData,
    output logic [31:0]       RamData,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              Busy
);

    localparam logic [3:0] CNT_LOAD =
        4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t            state;
    state_t            stateNext;
    op_t               op;
    logic [3:0]        waitCnt;
    logic              lastGrantWrite;
    logic [31:0]       ramDataQ;
    logic [ADDR_W-1:0] rdWord;
    logic [ADDR_W-1:0] wrWord;
    logic              grantValid;
    logic              grantWrite;
    logic              unusedAddrBits;

    assign rdWord = RamReadAddress[ADDR_W+1:2];
    assign wrWord = RamWriteAddress[ADDR_W+1:2];
    assign unusedAddrBits = ^{RamReadAddress[31:ADDR_W+2],
                              RamReadAddress[1:0],
                              RamWriteAddress[31:ADDR_W+2],
                              RamWriteAddress[1:0]};

    // Same word: write first so the read observes it; otherwise alternate.
    always_comb begin
        grantValid = RamRead || RamWrite;
        grantWrite = RamWrite &&
                     (!RamRead || (rdWord == wrWord) || !lastGrantWrite);
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (grantValid) begin
                    stateNext = (WAIT_CYCLES == 0) ? ISSUE : WAIT;
                end
            end
            WAIT: begin
                if (waitCnt == 4'd0) begin
                    stateNext = ISSUE;
                end
            end
            ISSUE: stateNext = DONE;
            DONE:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        mem_en          = (state == ISSUE);
        mem_we          = mem_en && (op == OP_WRITE);
        DoneReadingData = (state == DONE) && (op == OP_READ);
        DoneWritingData = (state == DONE) && (op == OP_WRITE);
        RamData         = DoneReadingData ? mem_rdata : ramDataQ;
        Busy            = (state != IDLE);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state          <= IDLE;
            op             <= OP_READ;
            waitCnt        <= 4'd0;
            lastGrantWrite <= 1'b1;
            mem_addr       <= '0;
            mem_wdata      <= 32'd0;
            ramDataQ       <= 32'd0;
        end else begin
            state <= stateNext;
            if (state == IDLE && grantValid) begin
                op             <= grantWrite ? OP_WRITE : OP_READ;
                mem_addr       <= grantWrite ? wrWord : rdWord;
                mem_wdata      <= RamWriteData;
                waitCnt        <= CNT_LOAD;
                lastGrantWrite <= grantWrite;
            end else if (state == WAIT && waitCnt != 4'd0) begin
                waitCnt <= waitCnt - 4'd1;
            end
            if (DoneReadingData) begin
                ramDataQ <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with SRAM models and a completion scoreboard.
// Covers the default wait-state instance and a zero-wait-state instance.
module tb_dmem_arbiter;

    typedef struct {
        logic        wr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        nReset;
    int          cyc = 0;
    int          nPass = 0;
    int          nFail = 0;
    int          t;
    exp_t        sb[$];
    exp_t        sb0[$];
    exp_t        e;

    logic        RamRead, RamWrite;
    logic [31:0] RamReadAddress, RamWriteAddress, RamWriteData;
    logic        DoneReadingData, DoneWritingData;
    logic [31:0] RamData;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        Busy;
    logic [31:0] mem4 [1024];

    logic        r0;
    logic [31:0] ra0;
    logic        w0;
    logic [31:0] wa0, wd0;
    logic        dr0, dw0;
    logic [31:0] rd0;
    logic        en0, we0;
    logic [9:0]  addr0;
    logic [31:0] wdat0, rdat0;
    logic        busy0;
    logic [31:0] mem0 [1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter #(.WAIT_CYCLES(4), .ADDR_W(10)) dut (
        .clk(clk), .nReset(nReset),
        .RamRead(RamRead), .RamReadAddress(RamReadAddress),
        .RamWrite(RamWrite), .RamWriteAddress(RamWriteAddress),
        .RamWriteData(RamWriteData),
        .DoneReadingData(DoneReadingData),
        .DoneWritingData(DoneWritingData),
        .RamData(RamData), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .Busy(Busy)
    );

    dmem_arbiter #(.WAIT_CYCLES(0), .ADDR_W(10)) dut0 (
        .clk(clk), .nReset(nReset),
        .RamRead(r0), .RamReadAddress(ra0),
        .RamWrite(w0), .RamWriteAddress(wa0),
        .RamWriteData(wd0),
        .DoneReadingData(dr0), .DoneWritingData(dw0),
        .RamData(rd0), .mem_en(en0), .mem_we(we0),
        .mem_addr(addr0), .mem_wdata(wdat0),
        .mem_rdata(rdat0), .Busy(busy0)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem4[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem4[mem_addr];
        end
        if (en0) begin
            if (we0) mem0[addr0] <= wdat0;
            else     rdat0 <= mem0[addr0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        assert (obs === exp) begin
            nPass++;
        end else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (DoneReadingData || DoneWritingData) begin
            chk("done_excl", 32'(DoneReadingData && DoneWritingData), 0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(cyc), 0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("done_type", 32'(DoneWritingData), 32'(e.wr));
                if (!e.wr) chk("rd_data", RamData, e.data);
            end
        end
        if (dr0 || dw0) begin
            if (sb0.size() == 0) begin
                chk("unexpected_done0", 32'(cyc), 0);
            end else begin
                e = sb0.pop_front();
                chk("done0_cycle", 32'(cyc), 32'(e.cyc));
                chk("done0_type", 32'(dw0), 32'(e.wr));
                if (!e.wr) chk("rd0_data", rd0, e.data);
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        mem4[4]  <= 32'hCAFEF00D;
        mem4[12] <= 32'h0BAD0BAD;
        mem4[16] <= 32'hBEEF0040;
        mem0[1]  <= 32'h11110004;
        mem0[2]  <= 32'h22220008;
        nReset = 1'b0;
        RamRead = 0; RamReadAddress = 0;
        RamWrite = 0; RamWriteAddress = 0; RamWriteData = 0;
        r0 = 0; ra0 = 0; w0 = 0; wa0 = 0; wd0 = 0;
        #3;
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_en", 32'(mem_en), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ramdata", RamData, 0);
        chk("rst_doner", 32'(DoneReadingData), 0);
        chk("rst_donew", 32'(DoneWritingData), 0);
        steps(2);
        nReset = 1'b1;
        step();

        // single read
        t = cyc;
        RamRead = 1; RamReadAddress = 32'h10;
        sb.push_back('{1'b0, 32'hCAFEF00D, t + 6});
        chk("rd_idle_busy", 32'(Busy), 0);
        steps(4);
        chk("rd_wait_en", 32'(mem_en), 0);
        step();
        chk("rd_issue_en", 32'(mem_en), 1);
        chk("rd_issue_we", 32'(mem_we), 0);
        chk("rd_issue_addr", 32'(mem_addr), 4);
        step();
        RamRead = 0;
        step();
        chk("rd_after_busy", 32'(Busy), 0);
        chk("rd_held", RamData, 32'hCAFEF00D);

        // single write then read-back
        t = cyc;
        RamWrite = 1; RamWriteAddress = 32'h20; RamWriteData = 32'h12345678;
        sb.push_back('{1'b1, 32'h0, t + 6});
        steps(5);
        chk("wr_issue_en", 32'(mem_en), 1);
        chk("wr_issue_we", 32'(mem_we), 1);
        chk("wr_issue_addr", 32'(mem_addr), 8);
        chk("wr_issue_data", mem_wdata, 32'h12345678);
        step();
        RamWrite = 0;
        step();
        t = cyc;
        RamRead = 1; RamReadAddress = 32'h20;
        sb.push_back('{1'b0, 32'h12345678, t + 6});
        steps(6);
        RamRead = 0;
        step();

        // simultaneous, different words, fresh from reset: read wins
        nReset = 0;
        step();
        nReset = 1;
        step();
        t = cyc;
        RamRead = 1; RamReadAddress = 32'h40;
        RamWrite = 1; RamWriteAddress = 32'h80; RamWriteData = 32'h5A5A;
        sb.push_back('{1'b0, 32'hBEEF0040, t + 6});
        sb.push_back('{1'b1, 32'h0, t + 13});
        steps(6);
        RamRead = 0;
        steps(6);
        chk("rr_wr_en", 32'(mem_en), 1);
        chk("rr_wr_we", 32'(mem_we), 1);
        chk("rr_wr_addr", 32'(mem_addr), 32'h20);
        step();
        RamWrite = 0;
        step();

        // simultaneous, same word: write first, read sees new data
        t = cyc;
        RamRead = 1; RamReadAddress = 32'h100;
        RamWrite = 1; RamWriteAddress = 32'h100;
        RamWriteData = 32'hA5A5A5A5;
        sb.push_back('{1'b1, 32'h0, t + 6});
        sb.push_back('{1'b0, 32'hA5A5A5A5, t + 13});
        steps(6);
        RamWrite = 0;
        steps(7);
        RamRead = 0;
        step();

        // request dropped mid-transaction
        t = cyc;
        RamRead = 1; RamReadAddress = 32'h10;
        sb.push_back('{1'b0, 32'hCAFEF00D, t + 6});
        steps(2);
        RamRead = 0;
        steps(5);
        chk("drop_idle", 32'(Busy), 0);
        steps(3);
        chk("drop_no_regrant", 32'(Busy), 0);

        // reset during a write aborts it
        t = cyc;
        RamWrite = 1; RamWriteAddress = 32'h30; RamWriteData = 32'hDEADBEEF;
        steps(3);
        chk("abort_busy_pre", 32'(Busy), 1);
        nReset = 0;
        #1;
        chk("abort_busy", 32'(Busy), 0);
        chk("abort_en", 32'(mem_en), 0);
        chk("abort_addr", 32'(mem_addr), 0);
        chk("abort_wdata", mem_wdata, 0);
        chk("abort_donew", 32'(DoneWritingData), 0);
        RamWrite = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_en_hold", 32'(mem_en), 0);
        end
        nReset = 1;
        t = cyc;
        RamRead = 1; RamReadAddress = 32'h30;
        sb.push_back('{1'b0, 32'h0BAD0BAD, t + 6});
        steps(6);
        RamRead = 0;
        step();

        // zero wait states, back-to-back reads
        t = cyc;
        r0 = 1; ra0 = 32'h4;
        sb0.push_back('{1'b0, 32'h11110004, t + 2});
        sb0.push_back('{1'b0, 32'h22220008, t + 5});
        step();
        chk("w0_en", 32'(en0), 1);
        chk("w0_addr", 32'(addr0), 1);
        step();
        ra0 = 32'h8;
        steps(3);
        r0 = 0;
        steps(2);
        chk("w0_idle", 32'(busy0), 0);

        chk("sb_empty", 32'(sb.size()), 0);
        chk("sb0_empty", 32'(sb0.size()), 0);
        $display("%0d/%0d checks passed", nPass, nPass + nFail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 4: backing-memory wait states per access, legal range 0..15.
REQ-002 The block SHALL have parameter ADDR_W, default 10: backing SRAM word-address width.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 nReset  in  1  reset, asynchronous, active-low.
REQ-005 RamRead  in  1  read request, level, held by the requester until DoneReadingData.
REQ-006 RamReadAddress  in  32  byte address of the read.
REQ-007 RamWrite  in  1  write request, level, held by the requester until DoneWritingData.
REQ-008 RamWriteAddress  in  32  byte address of the write.
REQ-009 RamWriteData  in  32  write data.
REQ-010 DoneReadingData  out  1  one-cycle read-complete pulse.
REQ-011 DoneWritingData  out  1  one-cycle write-complete pulse.
REQ-012 RamData  out  32  read data, valid while DoneReadingData is high.
REQ-013 mem_en  out  1  SRAM access strobe.
REQ-014 mem_we  out  1  SRAM write enable, qualified by mem_en.
REQ-015 mem_addr  out  ADDR_W  SRAM word address.
REQ-016 mem_wdata  out  32  SRAM write data.
REQ-017 mem_rdata  in  32  SRAM read data, valid the cycle after a read strobe.
REQ-018 Busy  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, WAIT, ISSUE and DONE; the transitions are IDLE->WAIT on grant (->ISSUE if WAIT_CYCLES=0), WAIT->ISSUE when the counter reaches 0, ISSUE->DONE, and DONE->IDLE, all unconditional apart from the grant.
REQ-020 On grant, the block SHALL latch the operation, mem address = address[ADDR_W+1:2] (bits 1:0 and upper bits ignored), and write data, and SHALL load the wait counter with WAIT_CYCLES-1.
REQ-021 During ISSUE, mem_en SHALL be 1, with mem_we=1 for a write; outside ISSUE, mem_en and mem_we SHALL be 0, and mem_addr/mem_wdata SHALL hold the latched values.
REQ-022 During DONE, the block SHALL pulse DoneReadingData (read) or DoneWritingData (write) for exactly one cycle, never both.
REQ-023 During a read DONE, RamData SHALL equal mem_rdata; that value SHALL be registered and held on RamData until the next read DONE.
REQ-024 Latency: if a request is seen in IDLE at cycle T, mem_en SHALL be high at T+WAIT_CYCLES+1 and Done at T+WAIT_CYCLES+2.
REQ-025 The block SHALL sample requests only in IDLE, so the cycle after DONE is IDLE; a request still high then SHALL be treated as a new transaction with its current address.
REQ-026 Arbitration with only one request SHALL grant that request.
REQ-027 Arbitration with both requests and word addresses equal SHALL grant the write first.
REQ-028 Arbitration with both requests and word addresses different SHALL be round-robin: grant the type not granted last; the last-grant bit resets to "write", so a read wins the first tie.
REQ-029 A request deasserted mid-transaction SHALL NOT abort the transaction: it completes with latched values and Done still pulses.
REQ-030 Request inputs that change while not in IDLE SHALL have no effect.

Reset
REQ-031 Assertion of nReset (any state) SHALL immediately force IDLE, counter 0, last-grant "write", RamData 0, Done pulses 0, mem_en/mem_we 0, mem_addr 0, mem_wdata 0, Busy 0.
REQ-032 Reset mid-transaction SHALL abort it with no Done pulse and no SRAM strobe; the first grant SHALL be possible in the first IDLE cycle after deassertion.

Structure
REQ-033 Package dmem_arb_pkg SHALL hold the state enum (IDLE, WAIT, ISSUE, DONE), the op enum (OP_READ, OP_WRITE) and the WAIT_CYCLES default.
REQ-034 The block SHALL have no sub-module; the single-port SRAM is external and the counter and arbiter are inline.

Verification
REQ-035 Single read with WAIT_CYCLES=4, RamRead=1 at T, address 0x0000_0010, SRAM word 4 = 0xCAFEF00D -> mem_en at T+5 with mem_addr=4, DoneReadingData at T+6 with RamData=0xCAFEF00D, Busy low at T+7.
REQ-036 Single write to 0x0000_0020 with data 0x1234_5678 -> mem_we=1 and mem_addr=8 at T+5, DoneWritingData at T+6; a subsequent read of 0x20 returns 0x1234_5678.
REQ-037 Simultaneous requests, read 0x40 and write 0x80, out of reset -> read served first (Done at T+6), write granted at T+7, DoneWritingData at T+13.
REQ-038 Simultaneous read and write, both to 0x100, write data 0xA5A5_A5A5 -> write completes first, then the read returns 0xA5A5_A5A5.
REQ-039 Read granted, then RamRead dropped at T+2 -> DoneReadingData still pulses at T+6 and no second grant occurs.
REQ-040 nReset asserted at T+3 of a write -> mem_en never asserted, no Done pulse, Busy=0 immediately; after release, a new read completes normally.
REQ-041 WAIT_CYCLES=0 with back-to-back reads 0x4 and 0x8 -> Done at T+2 and T+5.
